descrack_host: RTL

DESCRACK_HOST -- requirements
Module: descrack_host

---
 rtl/descrack_host.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/descrack_host.sv
// Host-link front end for the descrack key search engine: loads a 16-byte command,
// launches the search, then reports status and the 8-byte key result back to the host.
module descrack_host #(
  parameter int unsigned START_TO = 16,
  parameter logic [7:0]  STAT_OK  = 8'h00,
  parameter logic [7:0]  STAT_TO  = 8'hFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] crack_start,
  output logic [63:0] crack_goal,
  output logic        crack_run,
  input  logic        crack_busy,
  input  logic [63:0] crack_result
);

  localparam int unsigned   TW     = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [TW-1:0] ToLast = TW'(START_TO - 1);

  localparam logic [2:0] StLoad     = 3'd0;
  localparam logic [2:0] StLaunch   = 3'd1;
  localparam logic [2:0] StWait     = 3'd2;
  localparam logic [2:0] StSendStat = 3'd3;
  localparam logic [2:0] StSendRes  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [127:0]  key_q, key_d;
  logic [63:0]   res_q, res_d;
  logic          ok_q, ok_d;
  // Holds rx_ready low until the first clock edge after reset release.
  logic          en_q;

  logic rx_fire, tx_fire;

  assign crack_start = key_q[127:64];
  assign crack_goal  = key_q[63:0];
  assign rx_fire     = rx_valid & rx_ready;
  assign tx_fire     = tx_valid & tx_ready;

  always_comb begin
    rx_ready  = en_q && (state_q == StLoad);
    tx_valid  = (state_q == StSendStat) || (state_q == StSendRes);
    crack_run = (state_q == StLaunch);
    tx_data   = 8'h00;
    if (state_q == StSendStat) begin
      tx_data = ok_q ? STAT_OK : STAT_TO;
    end else if (state_q == StSendRes) begin
      tx_data = res_q[63:56];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    key_d   = key_q;
    res_d   = res_q;
    ok_d    = ok_q;
    case (state_q)
      StLoad: begin
        if (rx_fire) begin
          // start and goal form one 128-bit shift chain, so byte 0 ends in start[63:56].
          key_d = {key_q[119:0], rx_data};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = StLaunch;
            to_d    = '0;
          end
        end
      end
      StLaunch: begin
        // Busy wins over an expiring timeout.
        if (crack_busy) begin
          state_d = StWait;
        end else if (to_q == ToLast) begin
          state_d = StSendStat;
          ok_d    = 1'b0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      StWait: begin
        if (!crack_busy) begin
          res_d   = crack_result;
          ok_d    = 1'b1;
          state_d = StSendStat;
        end
      end
      StSendStat: begin
        if (tx_fire) begin
          state_d = ok_q ? StSendRes : StLoad;
          cnt_d   = 4'd0;
        end
      end
      StSendRes: begin
        if (tx_fire) begin
          res_d = {res_q[55:0], 8'h00};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = StLoad;
            cnt_d   = 4'd0;
          end
        end
      end
      default: begin
        state_d = StLoad;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StLoad;
      cnt_q   <= 4'd0;
      to_q    <= '0;
      key_q   <= '0;
      res_q   <= '0;
      ok_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      key_q   <= key_d;
      res_q   <= res_d;
      ok_q    <= ok_d;
      en_q    <= 1'b1;
    end
  end

endmodule
